mem_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one single-port `mem` instance between `NUM_REQ` requesters. Each requester presents a read or write with a valid/ready handshake. The arbiter grants one requester at a time and drives the memory's `valid_i`/`wr_rd_i`/`addr_i`/`wr_data_i` for exactly one cycle. It then waits for the memory's registered `ready_o` and returns read data plus a completion pulse to the granted requester. It sits between the requester ports and the memory instance, with a timeout guard so that a memory that never answers cannot hang the arbiter.

---
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer sharing one single-port
// memory between NUM_REQ requesters. One command per grant, a bounded wait
// for the memory's registered ready, then a one-cycle completion pulse.
module mem_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              rsp_rd_data_o,
    output logic [ID_WIDTH-1:0]           rsp_id_o,
    output logic                          rsp_err_o,
    output logic                          busy_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wr_data_o,
    input  logic [WIDTH-1:0]              mem_rd_data_i,
    input  logic                          mem_ready_i
);

    localparam int CW = ID_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic                    cmd_wr_q, cmd_wr_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [WIDTH-1:0]        cmd_data_q, cmd_data_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [WIDTH-1:0]        rsp_data_q, rsp_data_d;
    logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    busy_q, busy_d;
    logic                    mem_valid_q, mem_valid_d;

    logic                    sel_found;
    logic [ID_WIDTH-1:0]     sel_idx;
    logic [CW-1:0]           cand;
    logic [ID_WIDTH-1:0]     ptr_next;

    // Round-robin pick: first valid requester scanning from ptr, wrapping at NUM_REQ
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!sel_found && req_valid_i[cand[ID_WIDTH-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[ID_WIDTH-1:0];
            end
        end
    end

    // Pointer successor of the current grant with explicit wrap
    always_comb begin
        ptr_next = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + ID_WIDTH'(1);
    end

    // Next-state and registered-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        mem_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d     = sel_idx;
                    cmd_wr_d    = req_wr_rd_i[sel_idx];
                    cmd_addr_d  = req_addr_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    cmd_data_d  = req_wr_data_i[sel_idx*WIDTH +: WIDTH];
                    mem_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ready_i) begin
                    rsp_data_d  = cmd_wr_q ? '0 : mem_rd_data_i;
                    rsp_err_d   = 1'b0;
                    rsp_id_d    = grant_q;
                    req_ready_d = NUM_REQ'(1) << grant_q;
                    state_d     = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_id_d    = grant_q;
                    req_ready_d = NUM_REQ'(1) << grant_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                ptr_d      = ptr_next;
                rsp_data_d = '0;
                rsp_id_d   = '0;
                rsp_err_d  = 1'b0;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_rd_data_o = rsp_data_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_err_o     = rsp_err_q;
    assign busy_o        = busy_q;
    assign mem_valid_o   = mem_valid_q;
    assign mem_wr_rd_o   = cmd_wr_q;
    assign mem_addr_o    = cmd_addr_q;
    assign mem_wr_data_o = cmd_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural single-port memory with a stall control,
// requester drivers and a scoreboard of expected completions.
module tb_mem_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int IW    = 2;
    localparam int TO    = 15;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_wr_rd;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            rsp_err;
    logic            busy;
    logic            mem_valid;
    logic            mem_wr_rd;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic [W-1:0]    mem_rd;
    logic            mem_ready;
    logic            stall;

    logic [W-1:0]    mem_model [DEPTH];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   mv_cnt = 0;
    int   wait_cnt = 0;
    logic prev_mv = 1'b0;
    int   rem [N];
    exp_t sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with registered ready/read data, one cycle after valid
    always @(posedge clk) begin
        mem_ready <= mem_valid && !stall;
        if (mem_valid) begin
            if (mem_wr_rd) mem_model[mem_addr] <= mem_wdata;
            else           mem_rd <= mem_model[mem_addr];
        end
    end

    mem_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_wr_rd_i   (req_wr_rd),
        .req_addr_i    (req_addr),
        .req_wr_data_i (req_wdata),
        .req_ready_o   (req_ready),
        .rsp_rd_data_o (rsp_data),
        .rsp_id_o      (rsp_id),
        .rsp_err_o     (rsp_err),
        .busy_o        (busy),
        .mem_valid_o   (mem_valid),
        .mem_wr_rd_o   (mem_wr_rd),
        .mem_addr_o    (mem_addr),
        .mem_wr_data_o (mem_wdata),
        .mem_rd_data_i (mem_rd),
        .mem_ready_i   (mem_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [47:0] all_outs();
        return {req_ready, busy, mem_valid, mem_wr_rd, mem_addr, mem_wdata,
                rsp_data, rsp_id, rsp_err};
    endfunction

    task automatic expect_rsp(input int id, input logic [W-1:0] data, input logic err);
        exp_t e;
        e.id   = IW'(id);
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic issue(input int n, input logic wr, input logic [AW-1:0] a,
                         input logic [W-1:0] d, input int count);
        req_wr_rd[n]         = wr;
        req_addr[n*AW +: AW] = a;
        req_wdata[n*W +: W]  = d;
        rem[n]               = count;
        req_valid[n]         = 1'b1;
    endtask

    // Observe outputs mid-cycle, score completions and retire requests
    task automatic sample();
        exp_t e;
        if (mem_valid) begin
            check("valid_pulse", 64'(prev_mv), 64'd0);
            mv_cnt++;
        end
        prev_mv = mem_valid;
        if (busy && !mem_valid && req_ready == '0) wait_cnt++;
        if (req_ready != '0) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(req_ready), 64'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("ready_onehot", 64'(req_ready), 64'(N'(1) << e.id));
            end
            for (int n = 0; n < N; n++) begin
                if (req_ready[n]) begin
                    if (rem[n] > 0) rem[n]--;
                    if (rem[n] == 0) req_valid[n] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
    endtask

    task automatic wait_done(input int target, input int budget);
        int b;
        b = budget;
        while (done_cnt < target && b > 0) begin
            step();
            b--;
        end
        check("wait_done", 64'(done_cnt), 64'(target));
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        for (int n = 0; n < N; n++) rem[n] = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        step();
        step();
        check("reset_outs", 64'(all_outs()), 64'd0);
        rst = 1'b1;
        step();
    endtask

    initial begin
        int c0;
        int base;
        int t [4];
        rst       = 1'b0;
        stall     = 1'b0;
        req_valid = '0;
        req_wr_rd = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int n = 0; n < N; n++) rem[n] = 0;

        repeat (3) @(negedge clk);
        check("por_outs", 64'(all_outs()), 64'd0);
        rst = 1'b1;
        step();
        check("idle_outs", 64'(all_outs()), 64'd0);

        // Single requester: write then read back, 3-cycle completion latency
        expect_rsp(0, 16'h0000, 1'b0);
        issue(0, 1'b1, 6'd5, 16'hA5A5, 1);
        c0 = cyc;
        wait_done(1, 20);
        check("wr_latency", 64'(done_cyc - c0), 64'd3);
        step();
        expect_rsp(0, 16'hA5A5, 1'b0);
        issue(0, 1'b0, 6'd5, 16'h0000, 1);
        c0 = cyc;
        wait_done(2, 20);
        check("rd_latency", 64'(done_cyc - c0), 64'd3);

        // All four at once after reset: order 0..3, 4 cycles apart
        do_reset();
        base   = done_cnt;
        mv_cnt = 0;
        for (int n = 0; n < N; n++) begin
            expect_rsp(n, 16'h0000, 1'b0);
            issue(n, 1'b1, AW'(10 + n), W'(16'h1000 + n), 1);
        end
        for (int k = 0; k < 4; k++) begin
            wait_done(base + k + 1, 20);
            t[k] = done_cyc;
        end
        for (int k = 1; k < 4; k++) check("spacing", 64'(t[k] - t[k-1]), 64'd4);
        check("valid_pulses", 64'(mv_cnt), 64'd4);
        step();
        expect_rsp(0, 16'h1002, 1'b0);
        issue(0, 1'b0, 6'd12, 16'h0000, 1);
        wait_done(base + 5, 20);

        // Requesters 1 and 3 held valid: strict alternation over 20 accesses
        step();
        base = done_cnt;
        for (int k = 0; k < 10; k++) begin
            expect_rsp(1, 16'h0000, 1'b0);
            expect_rsp(3, 16'h0000, 1'b0);
        end
        issue(1, 1'b1, 6'd20, 16'h1111, 10);
        issue(3, 1'b1, 6'd30, 16'h3333, 10);
        wait_done(base + 20, 200);

        // Memory never answers: error completion after TIMEOUT wait cycles
        step();
        stall    = 1'b1;
        wait_cnt = 0;
        base     = done_cnt;
        expect_rsp(2, 16'h0000, 1'b1);
        issue(2, 1'b0, 6'd5, 16'h0000, 1);
        wait_done(base + 1, 40);
        check("timeout_wait_cycles", 64'(wait_cnt), 64'(TO));
        stall = 1'b0;
        step();
        expect_rsp(1, 16'hA5A5, 1'b0);
        issue(1, 1'b0, 6'd5, 16'h0000, 1);
        wait_done(base + 2, 20);

        // Reset during WAIT: immediate clear, no completion, pointer back to 0
        step();
        stall = 1'b1;
        base  = done_cnt;
        expect_rsp(2, 16'h0000, 1'b1);
        issue(2, 1'b0, 6'd5, 16'h0000, 1);
        for (int k = 0; k < 4; k++) step();
        check("in_wait", 64'({busy, mem_valid}), 64'(2'b10));
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_outs", 64'(all_outs()), 64'd0);
        clear_reqs();
        stall = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("no_rsp_interrupted", 64'(done_cnt), 64'(base));
        expect_rsp(0, 16'h0000, 1'b0);
        expect_rsp(3, 16'h0000, 1'b0);
        issue(0, 1'b1, 6'd40, 16'h4040, 1);
        issue(3, 1'b1, 6'd41, 16'h4141, 1);
        wait_done(base + 2, 30);

        // Top address written by one requester, read by another
        step();
        expect_rsp(3, 16'h0000, 1'b0);
        issue(3, 1'b1, 6'd63, 16'hBEEF, 1);
        wait_done(base + 3, 20);
        step();
        expect_rsp(1, 16'hBEEF, 1'b0);
        issue(1, 1'b0, 6'd63, 16'h0000, 1);
        wait_done(base + 4, 20);

        step();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
